// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Serializes a parallel word through an external WIDTH:1 mux. The word is held
// on mux_in while mux_sel walks every bit position. Each position is given
// HOLD_CYCLES cycles to settle before mux_out is offered downstream as a
// valid/ready/last bit stream.
// Build option: define MUX_SEQ_MSB_FIRST_EN to emit the MSB first (mux_sel
// walks WIDTH-1 down to 0). When it is undefined the LSB goes first.
module mux_sel_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SEL_W       = $clog2(WIDTH),
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  // Dwell counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] SEL_START = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_END   = '0;
`else
  localparam logic [SEL_W-1:0] SEL_START = '0;
  localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(WIDTH - 1);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   mux_in_reg, mux_in_next;
  logic [SEL_W-1:0]   mux_sel_reg, mux_sel_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic               s_ready_c;
  logic               m_valid_c;
  logic               at_end;

  assign at_end = (mux_sel_reg == SEL_END);

  // State register plus the word, select, dwell counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mux_in_reg  <= '0;
      mux_sel_reg <= SEL_START;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mux_in_reg  <= mux_in_next;
      mux_sel_reg <= mux_sel_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic: accept in IDLE, dwell and step the select in SCAN.
  always_comb begin
    state_next   = state_reg;
    mux_in_next  = mux_in_reg;
    mux_sel_next = mux_sel_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    s_ready_c    = 1'b0;
    m_valid_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          mux_in_next  = s_data;
          mux_sel_next = SEL_START;
          cnt_next     = '0;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        m_valid_c = (cnt_reg == CNT_MAX);
        if (!m_valid_c) begin
          // Still settling; once the counter reaches its limit it holds there.
          cnt_next = cnt_reg + CNT_ONE;
        end else if (m_ready) begin
          if (at_end) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
`ifdef MUX_SEQ_MSB_FIRST_EN
            mux_sel_next = mux_sel_reg - SEL_ONE;
`else
            mux_sel_next = mux_sel_reg + SEL_ONE;
`endif
            cnt_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  assign s_ready = s_ready_c & ~rst;
  assign m_valid = m_valid_c & ~rst;
  assign m_last  = m_valid & at_end;
  assign m_data  = mux_out;
  assign mux_in  = mux_in_reg;
  assign mux_sel = mux_sel_reg;
  assign busy    = (state_reg == SCAN);
  assign done    = done_reg;

`ifndef SYNTHESIS
  logic m_stall_reg;
  logic s_wait_reg;

  // Simulation-only check: pending valids must stay high until the handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_stall_reg <= 1'b0;
      s_wait_reg  <= 1'b0;
    end else begin
      m_stall_reg <= m_valid & ~m_ready;
      s_wait_reg  <= s_valid & ~s_ready;
      if (m_stall_reg) assert (m_valid);
      if (s_wait_reg) assert (s_valid);
    end
  end
`endif

endmodule
